// File: rtl/spi_regbank_pkg.sv
// spi_regbank_pkg : shared types and frame-geometry helpers for the SPI register bank. (rev 1.0)
`default_nettype none

package spi_regbank_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    DATA    = 3'd2,
    OVER    = 3'd3,
    WAIT_CS = 3'd4
  } state_t;

  localparam logic RW_WRITE = 1'b1;

  function automatic int frame_len(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

  function automatic int cnt_width(input int addr_w, input int data_w);
    return $clog2(frame_len(addr_w, data_w) + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_in_sync.sv
// spi_in_sync : multi-stage synchroniser with previous-value register and edge pulses. (rev 1.0)
`default_nettype none

module spi_in_sync
  import spi_regbank_pkg::*;
#(
  parameter int   SYNC_LENGTH = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_LENGTH-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {SYNC_LENGTH{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_LENGTH-2:0], din};
      r_prev <= r_sync[SYNC_LENGTH-1];
    end
  end

  assign level = r_sync[SYNC_LENGTH-1];
  assign rise  = level & ~r_prev;
  assign fall  = ~level & r_prev;

endmodule

`default_nettype wire

// File: rtl/spi_regbank.sv
// spi_regbank : mode-0 SPI slave register bank, commit on chip-select release. (rev 1.0)
// Optional CIPO read-back is built when SPI_READBACK_EN is defined.
`default_nettype none

module spi_regbank
  import spi_regbank_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 5,
  parameter int SYNC_LENGTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sclk,
  input  logic                       ncs,
  input  logic                       copi,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic                       frame_err
);

  localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
  localparam int CNT_W     = cnt_width(ADDR_W, DATA_W);
  localparam int SETTLE_W  = $clog2(SYNC_LENGTH + 3);

  localparam logic [CNT_W-1:0]    CNT_LAST_ADDR = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0]    CNT_LAST_DATA = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]    CNT_FRAME     = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0]    CNT_SAT       = CNT_W'(FRAME_LEN + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_DONE   = SETTLE_W'(SYNC_LENGTH + 2);

  logic w_sclk_s, w_sclk_rise, w_sclk_fall;
  logic w_ncs_s, w_ncs_rise, w_ncs_fall;
  logic w_copi_s, w_copi_rise, w_copi_fall;

  spi_in_sync #(.SYNC_LENGTH(SYNC_LENGTH), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk),
    .level(w_sclk_s), .rise(w_sclk_rise), .fall(w_sclk_fall)
  );

  spi_in_sync #(.SYNC_LENGTH(SYNC_LENGTH), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .din(ncs),
    .level(w_ncs_s), .rise(w_ncs_rise), .fall(w_ncs_fall)
  );

  spi_in_sync #(.SYNC_LENGTH(SYNC_LENGTH), .RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .din(copi),
    .level(w_copi_s), .rise(w_copi_rise), .fall(w_copi_fall)
  );

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [FRAME_LEN-1:0]  r_shift;
  logic                  r_ovf;
  logic [SETTLE_W-1:0]   r_settle;
  logic [FRAME_LEN-1:0]  w_next_shift;
  logic                  w_fresh;

  assign w_next_shift = {r_shift[FRAME_LEN-2:0], w_copi_s};
  // A chip select already low when reset releases shows up as a falling edge
  // while the synchroniser refills; such a frame must be skipped, not decoded.
  assign w_fresh      = (r_settle != SETTLE_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_ovf     <= 1'b0;
      r_settle  <= '0;
      regs_flat <= '0;
      wr_strobe <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_strobe <= '0;
      frame_err <= 1'b0;
      if (w_fresh) r_settle <= r_settle + 1'b1;
      case (r_state)
        IDLE: begin
          if (w_ncs_fall) begin
            r_state <= w_fresh ? WAIT_CS : ADDR;
            r_cnt   <= '0;
            r_shift <= '0;
            r_ovf   <= 1'b0;
          end
        end
        WAIT_CS: begin
          if (w_ncs_s) r_state <= IDLE;
        end
        ADDR, DATA, OVER: begin
          if (w_ncs_rise) begin
            r_state <= IDLE;
            if (r_cnt != CNT_FRAME || r_ovf) begin
              frame_err <= 1'b1;
            end else if (r_shift[FRAME_LEN-1] == RW_WRITE) begin
              for (int k = 0; k < NUM_REGS; k++) begin
                if (r_shift[DATA_W +: ADDR_W] == ADDR_W'(k)) begin
                  regs_flat[k*DATA_W +: DATA_W] <= r_shift[DATA_W-1:0];
                  wr_strobe[k]                  <= 1'b1;
                end
              end
            end
          end else if (w_sclk_rise) begin
            if (r_cnt != CNT_SAT) r_cnt <= r_cnt + 1'b1;
            if (r_state == OVER) begin
              r_ovf <= 1'b1;
            end else begin
              r_shift <= w_next_shift;
              if (r_state == ADDR && r_cnt == CNT_LAST_ADDR) r_state <= DATA;
              if (r_state == DATA && r_cnt == CNT_LAST_DATA) r_state <= OVER;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SPI_READBACK_EN
  logic [DATA_W-1:0] r_out_shift;
  logic [DATA_W-1:0] w_rd_word;
  logic              unused_edges;

  assign unused_edges = ^{w_copi_rise, w_copi_fall, w_sclk_s};

  always_comb begin
    w_rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (w_next_shift[ADDR_W-1:0] == ADDR_W'(k)) w_rd_word = regs_flat[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_shift <= '0;
      cipo        <= 1'b0;
      cipo_oe     <= 1'b0;
    end else if (r_state != ADDR && r_state != DATA) begin
      cipo    <= 1'b0;
      cipo_oe <= 1'b0;
    end else if (w_ncs_rise) begin
      cipo    <= 1'b0;
      cipo_oe <= 1'b0;
    end else if (r_state == ADDR) begin
      if (w_sclk_rise && r_cnt == CNT_LAST_ADDR && w_next_shift[ADDR_W] != RW_WRITE) begin
        r_out_shift <= w_rd_word;
        cipo_oe     <= 1'b1;
      end
    end else if (w_sclk_rise && r_cnt == CNT_LAST_DATA) begin
      cipo    <= 1'b0;
      cipo_oe <= 1'b0;
    end else if (cipo_oe && w_sclk_fall) begin
      cipo        <= r_out_shift[DATA_W-1];
      r_out_shift <= r_out_shift << 1;
    end
  end
`else
  logic unused_edges;

  assign unused_edges = ^{w_copi_rise, w_copi_fall, w_sclk_s, w_sclk_fall};
  assign cipo         = 1'b0;
  assign cipo_oe      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_regbank.sv
// tb_spi_regbank : directed self-checking bench for spi_regbank with default geometry.
`default_nettype none

module tb_spi_regbank;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int NREGS  = 5;
  localparam int FRAME  = 16;
  localparam int HALF   = 6;
`ifdef SPI_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk = 1'b0;
  logic ncs = 1'b1;
  logic copi = 1'b0;
  logic cipo, cipo_oe, frame_err;
  logic [NREGS*DATA_W-1:0] regs_flat;
  logic [NREGS-1:0] wr_strobe;

  int total = 0;
  int bad = 0;
  int strobe_hits [NREGS];
  int err_hits = 0;
  int oe_bad = 0;
  logic [31:0] cap;

  spi_regbank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NREGS), .SYNC_LENGTH(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ncs(ncs), .copi(copi),
    .cipo(cipo), .cipo_oe(cipo_oe), .regs_flat(regs_flat),
    .wr_strobe(wr_strobe), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int k = 0; k < NREGS; k++) if (wr_strobe[k]) strobe_hits[k]++;
    if (frame_err) err_hits++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_hits();
    for (int k = 0; k < NREGS; k++) strobe_hits[k] = 0;
    err_hits = 0;
    oe_bad   = 0;
    cap      = '0;
  endtask

  function automatic int strobe_sum();
    int s = 0;
    for (int k = 0; k < NREGS; k++) s += strobe_hits[k];
    return s;
  endfunction

  // Sends n bits of v MSB first; bit positions are counted from first_idx within the frame.
  task automatic send_bits(input logic [31:0] v, input int n, input int first_idx, input logic rd);
    for (int i = 0; i < n; i++) begin
      copi = v[n-1-i];
      wait_clk(HALF);
      if (cipo_oe !== (READBACK && rd && (first_idx + i) >= 1 + ADDR_W && (first_idx + i) < FRAME))
        oe_bad++;
      cap  = {cap[30:0], cipo};
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [31:0] v, input int n);
    logic [31:0] tmp;
    logic rd;
    tmp = v;
    rd  = (tmp[n-1] == 1'b0);
    ncs = 1'b0;
    wait_clk(HALF);
    send_bits(v, n, 0, rd);
    wait_clk(HALF);
    if (cipo_oe !== 1'b0) oe_bad++;
    ncs = 1'b1;
    wait_clk(12);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clk(4);
    total++; if (regs_flat !== '0) begin bad++; $display("FAIL reset_regs got=%h want=0", regs_flat); end
    total++; if (wr_strobe !== '0 || frame_err !== 1'b0) begin bad++; $display("FAIL reset_pulses strobe=%b err=%b want 0", wr_strobe, frame_err); end
    total++; if (cipo !== 1'b0 || cipo_oe !== 1'b0) begin bad++; $display("FAIL reset_cipo cipo=%b oe=%b want 0", cipo, cipo_oe); end
    rst = 1'b0;
    wait_clk(8);
  endtask

  task automatic test_write();
    clear_hits();
    spi_frame(32'h84AA, 16);
    total++; if (regs_flat !== 40'hAA_0000_0000) begin bad++; $display("FAIL write_reg4 got=%h want=aa00000000", regs_flat); end
    total++; if (strobe_hits[4] != 1 || strobe_sum() != 1) begin bad++; $display("FAIL write_strobe reg4_cycles=%0d total=%0d want 1/1", strobe_hits[4], strobe_sum()); end
    total++; if (err_hits != 0) begin bad++; $display("FAIL write_err got=%0d want 0", err_hits); end
  endtask

  task automatic test_out_of_range();
    clear_hits();
    spi_frame(32'h9055, 16);
    total++; if (regs_flat !== 40'hAA_0000_0000) begin bad++; $display("FAIL oor_regs got=%h want=aa00000000", regs_flat); end
    total++; if (strobe_sum() != 0 || err_hits != 0) begin bad++; $display("FAIL oor_pulses strobes=%0d err=%0d want 0/0", strobe_sum(), err_hits); end
  endtask

  task automatic test_bad_length();
    clear_hits();
    spi_frame(32'h0000_0221, 10);
    total++; if (err_hits != 1) begin bad++; $display("FAIL short_err got=%0d want 1", err_hits); end
    clear_hits();
    spi_frame(32'h0008_433F, 20);
    total++; if (err_hits != 1) begin bad++; $display("FAIL long_err got=%0d want 1", err_hits); end
    total++; if (regs_flat !== 40'hAA_0000_0000 || strobe_sum() != 0) begin bad++; $display("FAIL badlen_regs got=%h strobes=%0d want aa00000000/0", regs_flat, strobe_sum()); end
  endtask

  task automatic test_readback();
    logic [15:0] exp_cap;
    exp_cap = READBACK ? 16'h005C : 16'h0000;
    clear_hits();
    spi_frame(32'h825C, 16);
    total++; if (regs_flat[23:16] !== 8'h5C || strobe_hits[2] != 1) begin bad++; $display("FAIL rb_write reg2=%h strobes=%0d want 5c/1", regs_flat[23:16], strobe_hits[2]); end
    clear_hits();
    spi_frame(32'h0200, 16);
    total++; if (cap[15:0] !== exp_cap) begin bad++; $display("FAIL rb_cipo got=%h want=%h", cap[15:0], exp_cap); end
    total++; if (oe_bad != 0) begin bad++; $display("FAIL rb_oe bad_samples=%0d want 0", oe_bad); end
    total++; if (regs_flat[23:16] !== 8'h5C || strobe_sum() != 0 || err_hits != 0) begin bad++; $display("FAIL rb_nocommit reg2=%h strobes=%0d err=%0d want 5c/0/0", regs_flat[23:16], strobe_sum(), err_hits); end
  endtask

  task automatic test_back_to_back();
    clear_hits();
    spi_frame(32'h8001, 16);
    spi_frame(32'h8102, 16);
    total++; if (regs_flat !== 40'hAA_005C_0201) begin bad++; $display("FAIL b2b_regs got=%h want=aa005c0201", regs_flat); end
    total++; if (strobe_hits[0] != 1 || strobe_hits[1] != 1 || err_hits != 0) begin bad++; $display("FAIL b2b_strobes s0=%0d s1=%0d err=%0d want 1/1/0", strobe_hits[0], strobe_hits[1], err_hits); end
  endtask

  task automatic test_reset_midframe();
    clear_hits();
    ncs = 1'b0;
    wait_clk(HALF);
    send_bits(32'h0107, 9, 0, 1'b0);
    rst = 1'b1;
    wait_clk(3);
    total++; if (regs_flat !== '0) begin bad++; $display("FAIL midrst_clear got=%h want=0", regs_flat); end
    rst = 1'b0;
    wait_clk(HALF);
    send_bits(32'h007F, 7, 9, 1'b0);
    wait_clk(HALF);
    ncs = 1'b1;
    wait_clk(12);
    total++; if (regs_flat !== '0 || strobe_sum() != 0) begin bad++; $display("FAIL midrst_commit got=%h strobes=%0d want 0/0", regs_flat, strobe_sum()); end
    total++; if (err_hits != 0) begin bad++; $display("FAIL midrst_err got=%0d want 0", err_hits); end
    clear_hits();
    spi_frame(32'h8311, 16);
    total++; if (regs_flat !== 40'h00_1100_0000 || strobe_hits[3] != 1) begin bad++; $display("FAIL midrst_next got=%h s3=%0d want 0011000000/1", regs_flat, strobe_hits[3]); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_out_of_range();
    test_bad_length();
    test_readback();
    test_back_to_back();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
